eth_rx_stats: RTL and testbench



---
 rtl/eth_rx_stats.sv | 159 +++++++++++++++
 tb/tb_eth_rx_stats.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_stats.sv
// Receive-statistics block: tracks RMII frame boundaries, classifies each frame from the
// FCS verdict and firewall output, and keeps selectable counters for display.
module eth_rx_stats #(
    parameter int unsigned CNT_W    = 16,
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic        fcs_done,
    input  logic        fcs_kill,
    input  logic        fw_axiov,
    input  logic        clear,
    input  logic [2:0]  sel,
    output logic [31:0] stat_out,
    output logic        frame_ok
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRx, StTail, StDone} state_e;

    state_e            state_q, state_d;
    logic              axiiv_q, done_q;
    logic [31:0]       dibit_q, dibit_d, dibit_inc, len_src, len32;
    logic              fw_hit_q, fw_hit_d, fw_now;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]  cnt_q [6];
    logic [CNT_W-1:0]  cnt_d [6];
    logic [CNT_W-1:0]  len_fit;
    logic [31:0]       stat_q, stat_d;
    logic              frame_ok_q, frame_ok_d;
    logic              rise, fall, vrd, commit, abort, start;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (&v) return SATURATE ? v : '0;
        return v + CNT_W'(1);
    endfunction

    always_comb begin
        rise      = axiiv & ~axiiv_q;
        fall      = ~axiiv & axiiv_q;
        vrd       = fcs_done & ~done_q;
        fw_now    = fw_hit_q | fw_axiov;
        dibit_inc = (axiiv && !(&dibit_q)) ? dibit_q + 32'd1 : dibit_q;

        state_d  = state_q;
        dibit_d  = dibit_q;
        fw_hit_d = fw_hit_q;
        timer_d  = timer_q;
        commit   = 1'b0;
        abort    = 1'b0;
        start    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rise) start = 1'b1;
            end
            StRx: begin
                dibit_d  = dibit_inc;
                fw_hit_d = fw_now;
                if (vrd) begin
                    commit  = 1'b1;
                    state_d = axiiv ? StDone : StIdle;
                end else if (fall) begin
                    state_d = StTail;
                    timer_d = TW'(TIMEOUT);
                end
            end
            StTail: begin
                fw_hit_d = fw_now;
                timer_d  = timer_q - TW'(1);
                // Expiry is the cycle the timer steps to zero; a verdict there still commits.
                if (vrd) commit = 1'b1;
                else if (rise || timer_q <= TW'(1)) abort = 1'b1;
                if (commit || abort) state_d = StIdle;
                if (rise) start = 1'b1;
            end
            StDone: begin
                if (!axiiv) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d  = StRx;
            dibit_d  = 32'd1;
            fw_hit_d = fw_axiov;
        end
    end

    always_comb begin
        // The verdict cycle's own dibit counts when the frame is still on the wire.
        len_src = (state_q == StRx) ? dibit_inc : dibit_q;
        len32   = len_src >> 2;
        if (SATURATE && ((len32 >> CNT_W) != 32'd0)) len_fit = '1;
        else len_fit = len32[CNT_W-1:0];

        cnt_d      = cnt_q;
        frame_ok_d = 1'b0;
        if (clear) begin
            for (int i = 0; i < 6; i++) cnt_d[i] = '0;
        end else begin
            if (commit) begin
                cnt_d[0] = bump(cnt_q[0]);
                if (!fcs_kill) begin
                    cnt_d[1] = bump(cnt_q[1]);
                    if (fw_now) begin
                        cnt_d[3]   = bump(cnt_q[3]);
                        frame_ok_d = 1'b1;
                    end
                end else begin
                    cnt_d[2] = bump(cnt_q[2]);
                end
                cnt_d[5] = len_fit;
            end
            if (abort) cnt_d[4] = bump(cnt_q[4]);
        end

        case (sel)
            3'd0:    stat_d = 32'(cnt_q[0]);
            3'd1:    stat_d = 32'(cnt_q[1]);
            3'd2:    stat_d = 32'(cnt_q[2]);
            3'd3:    stat_d = 32'(cnt_q[3]);
            3'd4:    stat_d = 32'(cnt_q[4]);
            3'd5:    stat_d = 32'(cnt_q[5]);
            default: stat_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            axiiv_q    <= 1'b1;  // ignore a frame already in flight at reset release
            done_q     <= 1'b0;
            dibit_q    <= '0;
            fw_hit_q   <= 1'b0;
            timer_q    <= '0;
            for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
            stat_q     <= '0;
            frame_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            axiiv_q    <= axiiv;
            done_q     <= fcs_done;
            dibit_q    <= dibit_d;
            fw_hit_q   <= fw_hit_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            stat_q     <= stat_d;
            frame_ok_q <= frame_ok_d;
        end
    end

    assign stat_out = stat_q;
    assign frame_ok = frame_ok_q;

endmodule

// File: tb/tb_eth_rx_stats.sv
// Directed bench for eth_rx_stats: one default-parameter instance plus two 4-bit instances
// (saturating and wrapping) sharing the same stimulus.
module tb_eth_rx_stats;

    logic        clk = 1'b0;
    logic        rst, axiiv, fcs_done, fcs_kill, fw_axiov, clear;
    logic [2:0]  sel;
    logic [31:0] stat_main, stat_sat, stat_wrap;
    logic        ok_main, ok_sat, ok_wrap;

    int n_checks = 0;
    int n_pass   = 0;
    int ok_count = 0;
    int ok_base;

    always #5 clk = ~clk;

    eth_rx_stats #(.CNT_W(16), .SATURATE(1'b1), .TIMEOUT(64)) u_main (
        .clk(clk), .rst(rst), .axiiv(axiiv), .fcs_done(fcs_done), .fcs_kill(fcs_kill),
        .fw_axiov(fw_axiov), .clear(clear), .sel(sel), .stat_out(stat_main), .frame_ok(ok_main)
    );

    eth_rx_stats #(.CNT_W(4), .SATURATE(1'b1), .TIMEOUT(64)) u_sat (
        .clk(clk), .rst(rst), .axiiv(axiiv), .fcs_done(fcs_done), .fcs_kill(fcs_kill),
        .fw_axiov(fw_axiov), .clear(clear), .sel(sel), .stat_out(stat_sat), .frame_ok(ok_sat)
    );

    eth_rx_stats #(.CNT_W(4), .SATURATE(1'b0), .TIMEOUT(64)) u_wrap (
        .clk(clk), .rst(rst), .axiiv(axiiv), .fcs_done(fcs_done), .fcs_kill(fcs_kill),
        .fw_axiov(fw_axiov), .clear(clear), .sel(sel), .stat_out(stat_wrap), .frame_ok(ok_wrap)
    );

    always @(negedge clk) if (ok_main) ok_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] s);
        sel = s;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    // n dibits, fw_axiov on dibit fw_idx, verdict vdelay cycles after the fall cycle
    // (negative: no verdict), optional clear in the verdict cycle.
    task automatic send_frame(input int n, input int fw_idx, input int vdelay,
                              input logic kill, input logic clr_v, input logic exp_ok);
        for (int i = 0; i < n; i++) begin
            axiiv    = 1'b1;
            fw_axiov = (i == fw_idx);
            tick();
        end
        axiiv    = 1'b0;
        fw_axiov = 1'b0;
        if (vdelay >= 0) begin
            repeat (vdelay) tick();
            fcs_done = 1'b1;
            fcs_kill = kill;
            clear    = clr_v;
            tick();
            check("frame_ok_pulse", 32'(ok_main), 32'(exp_ok));
            fcs_done = 1'b0;
            fcs_kill = 1'b0;
            clear    = 1'b0;
            tick();
            check("frame_ok_width", 32'(ok_main), 32'd0);
            repeat (2) tick();
        end
    endtask

    initial begin
        rst = 1'b1; axiiv = 1'b0; fcs_done = 1'b0; fcs_kill = 1'b0;
        fw_axiov = 1'b0; clear = 1'b0; sel = 3'd0;
        repeat (3) tick();
        check("rst_stat_out", stat_main, 32'd0);
        check("rst_frame_ok", 32'(ok_main), 32'd0);
        rst = 1'b0;
        tick();
        rd(3'd0); check("rst_cnt0", stat_main, 32'd0);
        rd(3'd5); check("rst_cnt5", stat_main, 32'd0);

        // Good frame: 512 dibits -> length 128
        ok_base = ok_count;
        send_frame(512, 5, 2, 1'b0, 1'b0, 1'b1);
        rd(3'd0); check("good_cnt0", stat_main, 32'd1);
        rd(3'd1); check("good_cnt1", stat_main, 32'd1);
        rd(3'd2); check("good_cnt2", stat_main, 32'd0);
        rd(3'd3); check("good_cnt3", stat_main, 32'd1);
        rd(3'd4); check("good_cnt4", stat_main, 32'd0);
        rd(3'd5); check("good_cnt5", stat_main, 32'd128);
        rd(3'd6); check("good_sel6", stat_main, 32'd0);
        check("good_ok_pulses", 32'(ok_count - ok_base), 32'd1);

        // Bad FCS
        do_clear();
        ok_base = ok_count;
        send_frame(512, 5, 2, 1'b1, 1'b0, 1'b0);
        rd(3'd0); check("bad_cnt0", stat_main, 32'd1);
        rd(3'd1); check("bad_cnt1", stat_main, 32'd0);
        rd(3'd2); check("bad_cnt2", stat_main, 32'd1);
        rd(3'd3); check("bad_cnt3", stat_main, 32'd0);
        check("bad_ok_pulses", 32'(ok_count - ok_base), 32'd0);

        // Good FCS without firewall hit: 40 dibits -> 10
        do_clear();
        send_frame(40, -1, 3, 1'b0, 1'b0, 1'b0);
        rd(3'd1); check("nofw_cnt1", stat_main, 32'd1);
        rd(3'd3); check("nofw_cnt3", stat_main, 32'd0);
        rd(3'd5); check("nofw_cnt5", stat_main, 32'd10);

        // Timeout abort, then verdict landing exactly on the expiry cycle
        do_clear();
        send_frame(20, 0, -1, 1'b0, 1'b0, 1'b0);
        repeat (70) tick();
        rd(3'd4); check("to_cnt4", stat_main, 32'd1);
        rd(3'd0); check("to_cnt0", stat_main, 32'd0);
        rd(3'd5); check("to_cnt5_kept", stat_main, 32'd0);
        send_frame(24, 3, 64, 1'b0, 1'b0, 1'b1);
        rd(3'd0); check("exp_cnt0", stat_main, 32'd1);
        rd(3'd4); check("exp_cnt4", stat_main, 32'd1);
        rd(3'd5); check("exp_cnt5", stat_main, 32'd6);

        // Back-to-back frames with verdict inside each frame, one idle cycle between
        do_clear();
        ok_base = ok_count;
        for (int i = 0; i < 16; i++) begin
            axiiv = 1'b1; fw_axiov = (i == 0); fcs_done = (i == 15); tick();
        end
        axiiv = 1'b0; fw_axiov = 1'b0; fcs_done = 1'b0; tick();
        for (int i = 0; i < 33; i++) begin
            axiiv = 1'b1; fw_axiov = (i == 0); fcs_done = (i == 32); tick();
        end
        axiiv = 1'b0; fcs_done = 1'b0;
        repeat (3) tick();
        rd(3'd0); check("b2b_cnt0", stat_main, 32'd2);
        rd(3'd3); check("b2b_cnt3", stat_main, 32'd2);
        rd(3'd5); check("b2b_cnt5", stat_main, 32'd8);
        check("b2b_ok_pulses", 32'(ok_count - ok_base), 32'd2);

        // Clear coinciding with a commit
        send_frame(64, 2, 2, 1'b0, 1'b1, 1'b0);
        rd(3'd0); check("clr_cnt0", stat_main, 32'd0);
        rd(3'd1); check("clr_cnt1", stat_main, 32'd0);
        rd(3'd5); check("clr_cnt5", stat_main, 32'd0);
        send_frame(64, 2, 2, 1'b0, 1'b0, 1'b1);
        rd(3'd0); check("clr_next_cnt0", stat_main, 32'd1);

        // Reset mid-frame: the in-flight frame must not count
        axiiv = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        axiiv = 1'b0;
        repeat (2) tick();
        fcs_done = 1'b1; tick(); fcs_done = 1'b0;
        repeat (3) tick();
        rd(3'd0); check("rstmid_cnt0", stat_main, 32'd0);
        send_frame(32, 1, 2, 1'b0, 1'b0, 1'b1);
        rd(3'd0); check("rstmid_next_cnt0", stat_main, 32'd1);

        // 4-bit counters: saturate vs wrap
        do_clear();
        for (int f = 0; f < 17; f++) send_frame(8, 0, 2, 1'b0, 1'b0, 1'b1);
        rd(3'd1);
        check("sat_cnt1", stat_sat, 32'd15);
        check("wrap_cnt1", stat_wrap, 32'd1);
        check("main_cnt1_17", stat_main, 32'd17);
        send_frame(100, 0, 2, 1'b0, 1'b0, 1'b1);
        rd(3'd5);
        check("sat_cnt5", stat_sat, 32'd15);
        check("wrap_cnt5", stat_wrap, 32'd9);
        check("main_cnt5_25", stat_main, 32'd25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
